motor_ramp_ctrl: RTL
====================

Name: motor_ramp_ctrl

Overview:
Sequences the motor-control PWM generator. Accepts speed/direction commands and slews the 7-bit duty_cycle fed to the pwm block one step at a time at a programmed rate. Enforces ramp-to-zero plus a dead-time before any direction reversal. Provides an emergency stop. Sits between the command/register interface and the pwm instance; its duty_cycle and en outputs drive the pwm inputs of the same names.

Parameters:
STEP_DIV, 1000, clocks per ±1 duty step (≥1)
DEAD_CYCLES, 50, clocks of dead-time at duty 0 before a direction flip (≥1)
MAX_DUTY, 100, clamp ceiling for commanded duty (≤127)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted
cmd_duty  in  7  target duty (percent)
cmd_dir  in  1  target direction
estop  in  1  emergency stop, level, synchronous
duty_cycle  out  7  duty to pwm
en  out  1  pwm enable (level)
dir  out  1  motor direction to H-bridge
busy  out  1  ramp/dead-time in progress
at_target  out  1  duty_cycle equals accepted target, no reversal pending

Behaviour:
- clr asserted (async): duty_cycle=0, dir=0, en=0, busy=0, at_target=1, cmd_ready=1; state IDLE; target=0; pending_dir cleared; prescaler and dead counter =0. Reset mid-ramp aborts immediately.
- All outputs are registered.
- Handshake: accept on the clk edge where cmd_valid && cmd_ready. cmd_ready = !estop && state!=DEAD. A new accept overrides any earlier target (retarget mid-ramp allowed); there is no queue.
- On accept: target = min(cmd_duty, MAX_DUTY). If cmd_dir==dir, pending cleared. If cmd_dir!=dir and duty_cycle==0, dir flips on the accept edge, with no dead-time. If cmd_dir!=dir and duty_cycle>0, pending_dir=cmd_dir, saved_target=target, and the effective target becomes 0.
- States:
  - IDLE: duty=0, target=0, nothing pending.
  - RAMP: duty!=target.
  - DEAD: reversal dead-time.
  - RUN: duty==target, target>0.
- Transitions:
  - IDLE/RUN -> RAMP on an accept whose effective target differs from duty.
  - RAMP -> RUN/IDLE when duty reaches target.
  - RAMP -> DEAD when duty reaches 0 with pending set.
  - DEAD -> RAMP after DEAD_CYCLES clocks. On that edge dir=pending_dir, target=saved_target, pending cleared. If saved_target==0, go to IDLE instead.
- Ramp timing:
  - Prescaler clears to 0 on entry to RAMP and on any retarget accept.
  - Prescaler counts 0..STEP_DIV-1 while in RAMP. On the terminal count, duty moves 1 toward target and the prescaler wraps.
  - First step lands STEP_DIV clocks after entry.
  - Duty never overshoots target and never exceeds MAX_DUTY.
- DEAD: the counter clears on entry and the exit edge is at count DEAD_CYCLES-1. duty_cycle=0 throughout.
- en = 1 in RAMP, RUN and DEAD; 0 in IDLE.
- busy = state in {RAMP, DEAD}.
- at_target = state in {IDLE, RUN}.
- estop (highest priority, beats a simultaneous accept):
  - On the first edge with estop=1: duty_cycle=0, en=0, target=0, pending cleared, state IDLE; dir holds its value.
  - No ramp-down on estop.
  - Commands are ignored while estop is high. Normal operation resumes on the edge after estop falls.
- Width rules: all duty arithmetic is 7-bit unsigned. Counters are sized $clog2(max(STEP_DIV, DEAD_CYCLES)+1).

Test Plan:
- Reset/idle (STEP_DIV=4): pulse clr asynchronously mid-cycle -> outputs go to reset values immediately, before the next clk; cmd_ready=1.
- Ramp up: cmd_duty=5, dir=0 accepted at cycle T -> duty 1,2,3,4,5 at T+4,T+8,T+12,T+16,T+20. busy=1 and en=1 from T+1. At T+20 at_target=1, state RUN.
- Clamp and retarget (MAX_DUTY=100): cmd_duty=120 -> ramps toward 100. Retarget cmd_duty=3 while duty=10 -> prescaler restarts; duty steps down to 3 and stops, with no overshoot.
- Reversal (DEAD_CYCLES=3): at duty=2, dir=0, command cmd_dir=1, cmd_duty=2 -> duty ramps 1, 0; DEAD for 3 clocks with cmd_ready=0 and en=1; dir=1; duty ramps 1, 2; at_target=1.
- Estop mid-ramp at duty=7 with a simultaneous cmd_valid -> next edge duty=0, en=0, at_target=1, command not accepted. After estop falls, cmd_duty=2 is accepted and the ramp starts from 0.
- Zero-duty reversal: from IDLE, cmd_dir=1, cmd_duty=0 -> dir=1 on the accept edge; no DEAD state entered; busy stays 0.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motor_ramp_ctrl
//
// Sequences the motor PWM generator. Accepts speed/direction commands and
// slews duty_cycle one step at a time, one step every STEP_DIV clocks, toward
// the accepted target.
//
// A direction reversal while the motor is driven works like this:
//   1. ramp the duty down to zero;
//   2. hold a dead-time of DEAD_CYCLES clocks at duty zero;
//   3. flip dir and ramp up to the saved target.
//
// An emergency stop drops the drive to zero immediately. There is no ramp-down
// on an emergency stop.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   clr         in   1  asynchronous active-high reset
//   cmd_valid   in   1  command offered
//   cmd_ready   out  1  command can be accepted (not in estop, not in dead-time)
//   cmd_duty    in   7  target duty in percent (clamped to MAX_DUTY)
//   cmd_dir     in   1  target direction
//   estop       in   1  emergency stop, level, sampled on clk
//   duty_cycle  out  7  duty to the pwm block
//   en          out  1  pwm enable
//   dir         out  1  motor direction to the H-bridge
//   busy        out  1  ramp or dead-time in progress
//   at_target   out  1  duty equals accepted target, no reversal pending
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module motor_ramp_ctrl #(
  parameter int STEP_DIV    = 1000,
  parameter int DEAD_CYCLES = 50,
  parameter int MAX_DUTY    = 100
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_duty,
  input  logic       cmd_dir,
  input  logic       estop,
  output logic [6:0] duty_cycle,
  output logic       en,
  output logic       dir,
  output logic       busy,
  output logic       at_target
);

  // A single counter width covers both the prescaler and the dead-time counter.
  localparam int CNT_MAX = (STEP_DIV > DEAD_CYCLES) ? STEP_DIV : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [6:0]    DUTY_CEIL = 7'(MAX_DUTY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DEAD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Limit a requested duty to the ceiling.
  function automatic logic [6:0] clamp_duty(input logic [6:0] req);
    if (req > DUTY_CEIL) begin
      return DUTY_CEIL;
    end else begin
      return req;
    end
  endfunction

  // Move one unit toward the target. The result never passes the target.
  function automatic logic [6:0] step_toward(input logic [6:0] cur,
                                             input logic [6:0] tgt);
    if (cur < tgt) begin
      return cur + 7'd1;
    end else if (cur > tgt) begin
      return cur - 7'd1;
    end else begin
      return cur;
    end
  endfunction

  state_t        state_r, state_s;
  logic [6:0]    duty_r, duty_s;
  logic [6:0]    target_r, target_s;
  logic [6:0]    saved_target_r, saved_target_s;
  logic          pending_r, pending_s;
  logic          pending_dir_r, pending_dir_s;
  logic          dir_r, dir_s;
  logic [CW-1:0] presc_r, presc_s;
  logic [CW-1:0] dead_r, dead_s;
  logic          en_r, en_s;
  logic          busy_r, busy_s;
  logic          at_target_r, at_target_s;
  logic          cmd_ready_r, cmd_ready_s;

  logic          accept_s;
  logic [6:0]    req_s;
  logic [6:0]    eff_s;
  logic [6:0]    stepped_s;

  // Next-state computation: estop first, then accepts, then ramp/dead sequencing.
  always_comb begin
    state_s        = state_r;
    duty_s         = duty_r;
    target_s       = target_r;
    saved_target_s = saved_target_r;
    pending_s      = pending_r;
    pending_dir_s  = pending_dir_r;
    dir_s          = dir_r;
    presc_s        = presc_r;
    dead_s         = dead_r;

    accept_s  = cmd_valid && cmd_ready_r && !estop;
    req_s     = clamp_duty(cmd_duty);
    eff_s     = req_s;
    stepped_s = step_toward(duty_r, target_r);

    if (estop) begin
      // Drop the drive at once. dir is deliberately left where it is.
      state_s   = ST_IDLE;
      duty_s    = 7'd0;
      target_s  = 7'd0;
      pending_s = 1'b0;
      presc_s   = CNT_ZERO;
      dead_s    = CNT_ZERO;
    end else if (accept_s) begin
      presc_s = CNT_ZERO;
      if (cmd_dir == dir_r) begin
        pending_s = 1'b0;
        eff_s     = req_s;
      end else if (duty_r == 7'd0) begin
        // The motor is not driven, so the direction can flip without a dead-time.
        dir_s     = cmd_dir;
        pending_s = 1'b0;
        eff_s     = req_s;
      end else begin
        // Park the reversal: ramp to zero first, then restore the saved target.
        pending_s      = 1'b1;
        pending_dir_s  = cmd_dir;
        saved_target_s = req_s;
        eff_s          = 7'd0;
      end
      target_s = eff_s;
      if (eff_s != duty_r) begin
        state_s = ST_RAMP;
      end else if (eff_s == 7'd0) begin
        state_s = ST_IDLE;
      end else begin
        state_s = ST_RUN;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_RUN: begin
          state_s = ST_RUN;
        end
        ST_RAMP: begin
          if (presc_r == STEP_LAST) begin
            presc_s = CNT_ZERO;
            duty_s  = stepped_s;
            if (stepped_s == target_r) begin
              if (pending_r) begin
                state_s = ST_DEAD;
                dead_s  = CNT_ZERO;
              end else if (target_r == 7'd0) begin
                state_s = ST_IDLE;
              end else begin
                state_s = ST_RUN;
              end
            end else begin
              state_s = ST_RAMP;
            end
          end else begin
            presc_s = presc_r + CNT_ONE;
          end
        end
        ST_DEAD: begin
          if (dead_r == DEAD_LAST) begin
            dead_s    = CNT_ZERO;
            presc_s   = CNT_ZERO;
            dir_s     = pending_dir_r;
            target_s  = saved_target_r;
            pending_s = 1'b0;
            if (saved_target_r == 7'd0) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RAMP;
            end
          end else begin
            dead_s = dead_r + CNT_ONE;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          duty_s    = 7'd0;
          target_s  = 7'd0;
          pending_s = 1'b0;
          presc_s   = CNT_ZERO;
          dead_s    = CNT_ZERO;
        end
      endcase
    end

    // Status outputs are decoded from the next state so that they land as registers.
    en_s        = (state_s != ST_IDLE);
    busy_s      = (state_s == ST_RAMP) || (state_s == ST_DEAD);
    at_target_s = (state_s == ST_IDLE) || (state_s == ST_RUN);
    cmd_ready_s = !estop && (state_s != ST_DEAD);
  end

  // State and output registers. clr aborts any ramp immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r        <= ST_IDLE;
      duty_r         <= 7'd0;
      target_r       <= 7'd0;
      saved_target_r <= 7'd0;
      pending_r      <= 1'b0;
      pending_dir_r  <= 1'b0;
      dir_r          <= 1'b0;
      presc_r        <= CNT_ZERO;
      dead_r         <= CNT_ZERO;
      en_r           <= 1'b0;
      busy_r         <= 1'b0;
      at_target_r    <= 1'b1;
      cmd_ready_r    <= 1'b1;
    end else begin
      state_r        <= state_s;
      duty_r         <= duty_s;
      target_r       <= target_s;
      saved_target_r <= saved_target_s;
      pending_r      <= pending_s;
      pending_dir_r  <= pending_dir_s;
      dir_r          <= dir_s;
      presc_r        <= presc_s;
      dead_r         <= dead_s;
      en_r           <= en_s;
      busy_r         <= busy_s;
      at_target_r    <= at_target_s;
      cmd_ready_r    <= cmd_ready_s;
    end
  end

  assign duty_cycle = duty_r;
  assign dir        = dir_r;
  assign en         = en_r;
  assign busy       = busy_r;
  assign at_target  = at_target_r;
  assign cmd_ready  = cmd_ready_r;

endmodule
